// File: rtl/alu_share_arbiter_if.sv
// ---------------------------------------------------------------------------
// alu_share_arbiter_if
//
// Bundles every signal between the ALU share arbiter, its two requesters,
// the shared ALU (control unit + datapath) and the response consumer.
//
//   req_valid[i]   requester i presents an op
//   req_ready[i]   op of requester i accepted when valid && ready at an edge
//   req_aluop[i]   2-bit ALU op class of requester i
//   req_func[i]    4-bit function field of requester i
//   req_a[i]       operand A of requester i
//   req_b[i]       operand B of requester i
//   alu_aluop      op class driven to the ALU control unit
//   alu_func       function field driven to the ALU control unit
//   alu_a, alu_b   operands driven to the ALU
//   alu_ctrl_in    control word coming back from the ALU control unit
//   alu_result     ALU result
//   alu_zero       ALU zero flag
//   resp_valid     a response is presented
//   resp_id        index of the requester that issued the op
//   resp_result    captured ALU result
//   resp_zero      captured zero flag
//   resp_err       op decoded to the invalid control word 4'b1111
//   resp_ready     consumer takes the response
//
// Modports: slave = arbiter side, master = environment side.
// ---------------------------------------------------------------------------
interface alu_share_arbiter_if #(
    parameter int DATA_W = 32
);
    logic [1:0]             req_valid;
    logic [1:0]             req_ready;
    logic [1:0][1:0]        req_aluop;
    logic [1:0][3:0]        req_func;
    logic [1:0][DATA_W-1:0] req_a;
    logic [1:0][DATA_W-1:0] req_b;

    logic [1:0]             alu_aluop;
    logic [3:0]             alu_func;
    logic [DATA_W-1:0]      alu_a;
    logic [DATA_W-1:0]      alu_b;
    logic [3:0]             alu_ctrl_in;
    logic [DATA_W-1:0]      alu_result;
    logic                   alu_zero;

    logic                   resp_valid;
    logic                   resp_id;
    logic [DATA_W-1:0]      resp_result;
    logic                   resp_zero;
    logic                   resp_err;
    logic                   resp_ready;

    modport slave (
        input  req_valid, req_aluop, req_func, req_a, req_b,
        output req_ready,
        output alu_aluop, alu_func, alu_a, alu_b,
        input  alu_ctrl_in, alu_result, alu_zero,
        output resp_valid, resp_id, resp_result, resp_zero, resp_err,
        input  resp_ready
    );

    modport master (
        output req_valid, req_aluop, req_func, req_a, req_b,
        input  req_ready,
        input  alu_aluop, alu_func, alu_a, alu_b,
        output alu_ctrl_in, alu_result, alu_zero,
        input  resp_valid, resp_id, resp_result, resp_zero, resp_err,
        output resp_ready
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// ---------------------------------------------------------------------------
// alu_share_arbiter
//
// Shares one combinational ALU between two requesters. An accepted op is
// registered and presented to the ALU for exactly one cycle (EXEC), the ALU
// outcome is captured, and the response is held in RESP until consumed.
// A new op can be accepted in the same cycle the response is consumed, so
// back-to-back traffic runs at one op every two cycles.
//
// Ports:
//   clk   single clock, rising edge
//   rst   synchronous, active-high reset
//   bus   alu_share_arbiter_if.slave (request, ALU and response signals)
//
// Configuration:
//   ALU_ARB_ROUND_ROBIN_EN  defined   -> simultaneous requests alternate,
//                                        starting from requester 0 after reset
//                           undefined -> fixed priority, requester 0 wins
// ---------------------------------------------------------------------------
module alu_share_arbiter #(
    parameter int DATA_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    alu_share_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;

    logic              grant_en;   // arbitration is open this cycle
    logic              winner;     // index that would win if it is valid
    logic [1:0]        grant;
    logic              accept;

    // Registered op; these also drive the ALU directly, so the ALU inputs
    // only change on acceptance and hold otherwise.
    logic [1:0]        aluop_q;
    logic [3:0]        func_q;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic              op_id_q;

    // Captured response
    logic              resp_id_q;
    logic [DATA_W-1:0] result_q;
    logic              zero_q;
    logic [3:0]        ctrl_q;

    // -----------------------------------------------------------------------
    // Arbitration
    // -----------------------------------------------------------------------
`ifdef ALU_ARB_ROUND_ROBIN_EN
    logic last_grant;

    // Starts at 1 so the first contended grant after reset goes to 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 1'b1;
        end else if (accept) begin
            last_grant <= winner;
        end
    end
`endif

    always_comb begin
        winner = 1'b0;
        unique case (bus.req_valid)
            2'b10: winner = 1'b1;
`ifdef ALU_ARB_ROUND_ROBIN_EN
            2'b11: winner = ~last_grant;
`else
            2'b11: winner = 1'b0;
`endif
            default: winner = 1'b0;
        endcase
    end

    assign grant  = grant_en ? ((winner ? 2'b10 : 2'b01) & bus.req_valid) : 2'b00;
    assign accept = |grant;

    // -----------------------------------------------------------------------
    // FSM
    // -----------------------------------------------------------------------
    // NOTE: sequential logic uses non-blocking assignments so every register
    // samples the values from before the clock edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        grant_en  = 1'b0;
        unique case (state)
            IDLE: begin
                grant_en = 1'b1;
                if (|bus.req_valid) begin
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                state_nxt = RESP;
            end
            RESP: begin
                // Arbitration reopens only once the response is consumed.
                if (bus.resp_ready) begin
                    grant_en  = 1'b1;
                    state_nxt = (|bus.req_valid) ? EXEC : IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Datapath
    // -----------------------------------------------------------------------
    // NOTE: these payload registers are reset because their zero values are
    // visible on the ALU inputs and the response port after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            aluop_q   <= 2'b00;
            func_q    <= 4'b0000;
            a_q       <= '0;
            b_q       <= '0;
            op_id_q   <= 1'b0;
            resp_id_q <= 1'b0;
            result_q  <= '0;
            zero_q    <= 1'b0;
            ctrl_q    <= 4'b0000;
        end else begin
            if (accept) begin
                aluop_q <= bus.req_aluop[winner];
                func_q  <= bus.req_func[winner];
                a_q     <= bus.req_a[winner];
                b_q     <= bus.req_b[winner];
                op_id_q <= winner;
            end
            // The ALU sees the registered op during EXEC; its outcome is
            // captured on the edge that ends EXEC.
            if (state == EXEC) begin
                resp_id_q <= op_id_q;
                result_q  <= bus.alu_result;
                zero_q    <= bus.alu_zero;
                ctrl_q    <= bus.alu_ctrl_in;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign bus.req_ready   = grant;

    assign bus.alu_aluop   = aluop_q;
    assign bus.alu_func    = func_q;
    assign bus.alu_a       = a_q;
    assign bus.alu_b       = b_q;

    assign bus.resp_valid  = (state == RESP);
    assign bus.resp_id     = resp_id_q;
    assign bus.resp_result = result_q;
    assign bus.resp_zero   = zero_q;
    // 4'b1111 is the control unit's "invalid op" code; the result is
    // still returned alongside the error flag.
    assign bus.resp_err    = (ctrl_q == 4'b1111);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_share_arbiter
//
// Environment for alu_share_arbiter: two requesters, a behavioural ALU
// (control unit + datapath) and a response consumer. A monitor keeps a
// transaction-level model (who wins, when the block is free, what each op
// must return) and compares the DUT against it every cycle; directed
// sequences exercise single op, invalid op, backpressure, contention and
// reset during RESP, followed by a randomized phase.
// ---------------------------------------------------------------------------
module tb_alu_share_arbiter;

    localparam int DW = 32;

    logic clk;
    logic rst;

    alu_share_arbiter_if #(.DATA_W(DW)) bus ();

    alu_share_arbiter #(.DATA_W(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // -----------------------------------------------------------------------
    // Behavioural ALU control unit + ALU
    // -----------------------------------------------------------------------
    function automatic logic [3:0] ctrl_of(input logic [1:0] aluop, input logic [3:0] func);
        case (aluop)
            2'b00: return 4'b0010;
            2'b01: return 4'b0110;
            2'b10: begin
                case (func)
                    4'b0000: return 4'b0010;
                    4'b0010: return 4'b0110;
                    4'b0100: return 4'b0000;
                    4'b0101: return 4'b0001;
                    4'b1010: return 4'b0111;
                    default: return 4'b1111;
                endcase
            end
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [DW-1:0] alu_calc(input logic [3:0] ctrl, input logic [DW-1:0] a,
                                               input logic [DW-1:0] b);
        case (ctrl)
            4'b0010: return a + b;
            4'b0110: return a - b;
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0111: return ($signed(a) < $signed(b)) ? DW'(1) : DW'(0);
            default: return a ^ b;
        endcase
    endfunction

    assign bus.alu_ctrl_in = ctrl_of(bus.alu_aluop, bus.alu_func);
    assign bus.alu_result  = alu_calc(ctrl_of(bus.alu_aluop, bus.alu_func), bus.alu_a, bus.alu_b);
    assign bus.alu_zero    = (bus.alu_result == '0);

    // -----------------------------------------------------------------------
    // Checking infrastructure
    // -----------------------------------------------------------------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    int   cyc   = 0;
    logic rst_d = 1'b1;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_d <= rst;
    end

    // -----------------------------------------------------------------------
    // Reference model and scoreboard
    // -----------------------------------------------------------------------
    typedef struct packed {
        logic [1:0]    aluop;
        logic [3:0]    func;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
    } op_t;

    typedef struct {
        logic          id;
        logic [DW-1:0] result;
        logic          zero;
        logic          err;
        int            acc_cyc;
    } exp_t;

    exp_t exp_q[$];
    logic last_grant_m;
    op_t  last_op;

    // Who wins among the valid requesters.
    function automatic logic pick(input logic [1:0] v, input logic last);
        if (v == 2'b10) return 1'b1;
        if (v == 2'b11) begin
`ifdef ALU_ARB_ROUND_ROBIN_EN
            return ~last;
`else
            return 1'b0;
`endif
        end
        return 1'b0;
    endfunction

    initial begin : monitor
        logic       due;
        logic       mw;
        logic [1:0] er;
        logic [3:0] ctrl;
        exp_t       e;
        op_t        cur;
        forever begin
            @(negedge clk);
            if (rst) begin
                // Reset will land on the next edge: everything in flight is gone.
                exp_q.delete();
                last_grant_m = 1'b1;
                last_op      = '0;
            end else begin
                if (rst_d) begin
                    check("reset_resp", {bus.resp_valid, bus.resp_id, bus.resp_zero,
                                         bus.resp_err, bus.resp_result}, '0);
                    check("reset_alu", {bus.alu_aluop, bus.alu_func, bus.alu_a, bus.alu_b}, '0);
                end
                check("alu_inputs", {bus.alu_aluop, bus.alu_func, bus.alu_a, bus.alu_b}, last_op);

                // A response is due two cycles after its acceptance.
                due = (exp_q.size() != 0) && (cyc >= exp_q[0].acc_cyc + 2);
                check("resp_valid", bus.resp_valid, due);
                if (due && bus.resp_valid) begin
                    check("resp_fields", {bus.resp_id, bus.resp_zero, bus.resp_err, bus.resp_result},
                          {exp_q[0].id, exp_q[0].zero, exp_q[0].err, exp_q[0].result});
                end
                if (due && bus.resp_ready) begin
                    void'(exp_q.pop_front());
                end

                // The ALU is free once nothing is outstanding (or the pending
                // response is consumed this very cycle).
                mw = pick(bus.req_valid, last_grant_m);
                er = ((exp_q.size() == 0) && (bus.req_valid != 2'b00)) ? (mw ? 2'b10 : 2'b01) : 2'b00;
                check("req_ready", bus.req_ready, er);
                if (er != 2'b00) begin
                    cur.aluop = bus.req_aluop[mw];
                    cur.func  = bus.req_func[mw];
                    cur.a     = bus.req_a[mw];
                    cur.b     = bus.req_b[mw];
                    ctrl      = ctrl_of(cur.aluop, cur.func);
                    e.id      = mw;
                    e.result  = alu_calc(ctrl, cur.a, cur.b);
                    e.zero    = (e.result == '0);
                    e.err     = (ctrl == 4'b1111);
                    e.acc_cyc = cyc;
                    exp_q.push_back(e);
                    last_grant_m = mw;
                    last_op      = cur;
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Stimulus helpers
    // -----------------------------------------------------------------------
    task automatic tick(output logic [1:0] acc);
        @(negedge clk);
        acc = bus.req_valid & bus.req_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [1:0] aluop, input logic [3:0] func,
                          input logic [DW-1:0] a, input logic [DW-1:0] b);
        bus.req_valid[i] = 1'b1;
        bus.req_aluop[i] = aluop;
        bus.req_func[i]  = func;
        bus.req_a[i]     = a;
        bus.req_b[i]     = b;
    endtask

    task automatic set_random(input int i);
        logic [3:0]    funcs [6];
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        funcs = '{4'b0000, 4'b0010, 4'b0100, 4'b0101, 4'b1010, 4'b1111};
        a = $urandom;
        b = ($urandom_range(0, 3) == 0) ? a : DW'($urandom);
        set_op(i, 2'($urandom_range(0, 3)), funcs[$urandom_range(0, 5)], a, b);
    endtask

    task automatic wait_accept(input int i);
        logic [1:0] acc;
        int         n;
        n = 0;
        acc = 2'b00;
        while (!acc[i] && n < 50) begin
            tick(acc);
            n++;
        end
        check($sformatf("accept_req%0d", i), acc[i], 1'b1);
    endtask

    task automatic wait_resp_valid(input string name);
        logic [1:0] acc;
        int         n;
        n = 0;
        while (!bus.resp_valid && n < 20) begin
            tick(acc);
            n++;
        end
        check(name, bus.resp_valid, 1'b1);
    endtask

    task automatic idle_bus(input int n);
        logic [1:0] acc;
        bus.req_valid  = 2'b00;
        bus.resp_ready = 1'b1;
        repeat (n) tick(acc);
    endtask

    // -----------------------------------------------------------------------
    // Main sequence
    // -----------------------------------------------------------------------
    logic [1:0]    acc;
    logic [DW-1:0] ta;
    logic [DW-1:0] tb;
    logic [127:0]  snap;
    int            ng;
    int            prev;
    logic          g;
    logic          eg;

    initial begin
        rst            = 1'b1;
        bus.req_valid  = 2'b00;
        bus.req_aluop  = '0;
        bus.req_func   = '0;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.resp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        idle_bus(2);

        // Single op: 5 + 7 through aluop=10/func=0000
        set_op(0, 2'b10, 4'b0000, DW'(5), DW'(7));
        wait_accept(0);
        bus.req_valid[0] = 1'b0;
        @(negedge clk);
        check("single_exec_alu", {bus.alu_aluop, bus.alu_func, bus.alu_a, bus.alu_b},
              {2'b10, 4'b0000, DW'(5), DW'(7)});
        check("single_exec_no_resp", bus.resp_valid, 1'b0);
        @(negedge clk);
        check("single_resp", {bus.resp_valid, bus.resp_id, bus.resp_err, bus.resp_result},
              {1'b1, 1'b0, 1'b0, DW'(12)});
        @(posedge clk);
        #1;
        idle_bus(2);

        // Invalid op from requester 1
        ta = $urandom;
        tb = $urandom;
        set_op(1, 2'b10, 4'b1111, ta, tb);
        wait_accept(1);
        bus.req_valid[1] = 1'b0;
        @(negedge clk);
        check("invalid_exec_func", bus.alu_func, 4'b1111);
        @(negedge clk);
        check("invalid_resp", {bus.resp_valid, bus.resp_id, bus.resp_err, bus.resp_result},
              {1'b1, 1'b1, 1'b1, ta ^ tb});
        @(posedge clk);
        #1;
        idle_bus(2);

        // Backpressure: response held 5 cycles while requester 1 waits
        bus.resp_ready = 1'b0;
        set_op(0, 2'b01, 4'b0000, DW'(100), DW'(58));
        wait_accept(0);
        bus.req_valid[0] = 1'b0;
        wait_resp_valid("bp_resp_seen");
        set_random(1);
        snap = {bus.resp_id, bus.resp_zero, bus.resp_err, bus.resp_result};
        check("bp_first", snap, {1'b0, 1'b0, 1'b0, DW'(42)});
        repeat (5) begin
            @(negedge clk);
            check("bp_hold", {bus.resp_valid, bus.resp_id, bus.resp_zero, bus.resp_err, bus.resp_result},
                  {1'b1, snap[34:0]});
            check("bp_ready_low", bus.req_ready, 2'b00);
        end
        @(posedge clk);
        #1;
        bus.resp_ready = 1'b1;
        @(negedge clk);
        check("bp_release_accept", bus.req_ready, 2'b10);
        @(posedge clk);
        #1;
        bus.req_valid[1] = 1'b0;
        idle_bus(4);

        // Contention: both requesters valid continuously
        set_random(0);
        set_random(1);
        ng   = 0;
        prev = 0;
        for (int k = 0; k < 40 && ng < 8; k++) begin
            tick(acc);
            if (acc != 2'b00) begin
                g = acc[1];
`ifdef ALU_ARB_ROUND_ROBIN_EN
                eg = (ng % 2) == 1;
`else
                eg = 1'b0;
`endif
                check("contention_grant", g, eg);
                if (ng > 0) check("contention_gap", cyc - prev, 2);
                prev = cyc;
                ng++;
                set_random(int'(g));
            end
        end
        check("contention_count", ng, 8);
        idle_bus(4);

        // Reset while a response is pending
        bus.resp_ready = 1'b0;
        set_random(0);
        wait_accept(0);
        bus.req_valid[0] = 1'b0;
        wait_resp_valid("rst_resp_seen");
        set_random(0);
        set_random(1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst            = 1'b0;
        bus.resp_ready = 1'b1;
        @(negedge clk);
        check("rst_resp_dropped", bus.resp_valid, 1'b0);
        check("rst_first_grant", bus.req_ready, 2'b01);
        @(posedge clk);
        #1;
        bus.req_valid[0] = 1'b0;
        wait_accept(1);
        bus.req_valid[1] = 1'b0;
        idle_bus(4);

        // Randomized traffic with random backpressure
        for (int n = 0; n < 400; n++) begin
            tick(acc);
            for (int i = 0; i < 2; i++) begin
                if (!bus.req_valid[i] || acc[i]) begin
                    if ($urandom_range(0, 2) != 0) set_random(i);
                    else bus.req_valid[i] = 1'b0;
                end
            end
            bus.resp_ready = ($urandom_range(0, 3) != 0);
        end
        idle_bus(8);
        check("drain_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_share_arbiter.md
ALU_SHARE_ARBITER -- requirements
Module: alu_share_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, giving the operand and result width.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock, with all state updating on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have ports req_valid[i], input, 1 bit (i=0,1): requester i presents an op.
REQ-005 The block SHALL have ports req_ready[i], output, 1 bit: requester i's op is accepted when req_valid[i] and req_ready[i] are both high at a clock edge.
REQ-006 The block SHALL have per-requester inputs req_aluop[i] (2 bits), req_func[i] (4 bits), req_a[i] (DATA_W bits) and req_b[i] (DATA_W bits).
REQ-007 The block SHALL have outputs alu_aluop (2 bits) and alu_func (4 bits), which drive the ALU control unit.
REQ-008 The block SHALL have outputs alu_a and alu_b, each DATA_W bits, which drive the ALU operands.
REQ-009 The block SHALL have inputs alu_ctrl_in (4 bits, ALU control unit output), alu_result (DATA_W bits) and alu_zero (1 bit).
REQ-010 The block SHALL have outputs resp_valid (1 bit), resp_id (1 bit, requester index), resp_result (DATA_W bits), resp_zero (1 bit) and resp_err (1 bit), and input resp_ready (1 bit).

Function
REQ-011 The block SHALL share one ALU between two requesters using an FSM with states IDLE, EXEC and RESP.
REQ-012 In IDLE, req_ready SHALL be high only for the arbitration winner, and only when that winner's req_valid is high.
REQ-013 On acceptance, the block SHALL register the winner's aluop, func, a, b and index, then move to EXEC.
REQ-014 In EXEC (exactly one cycle), the alu_* outputs SHALL present the registered op; at the end of EXEC the block SHALL capture alu_result, alu_zero and alu_ctrl_in, then move to RESP.
REQ-015 Outside EXEC, alu_aluop, alu_func, alu_a and alu_b SHALL hold their last values, so the ALU inputs do not toggle.
REQ-016 resp_err SHALL be 1 when the captured alu_ctrl_in equals 4'b1111 (invalid op); the result is still returned.
REQ-017 In RESP, resp_valid SHALL be 1, and resp_id, resp_result, resp_zero and resp_err SHALL hold stable until resp_ready is 1.
REQ-018 In RESP with resp_ready=0, the block SHALL stay in RESP, with all req_ready low.
REQ-019 In RESP with resp_ready=1 and no req_valid, the block SHALL go to IDLE.
REQ-020 In RESP with resp_ready=1 and any req_valid, req_ready SHALL go high for the winner, which is accepted in the same cycle, and the block SHALL go directly to EXEC.
REQ-021 Latency from acceptance to resp_valid SHALL be 2 cycles; sustained throughput SHALL be one op per 2 cycles.
REQ-022 Arbitration SHALL be evaluated only in IDLE and in RESP with resp_ready=1.
REQ-023 When only one req_valid is high, that requester SHALL win.
REQ-024 With simultaneous requests, the winner SHALL be chosen per REQ-030 and REQ-031.
REQ-025 A requester SHALL hold req_valid and its payload until accepted; the block need not handle withdrawal before acceptance.

Reset
REQ-026 While rst=1 at a clock edge, the FSM SHALL go to IDLE.
REQ-027 Reset SHALL force resp_valid=0, resp_id=0, resp_result=0, resp_zero=0 and resp_err=0.
REQ-028 Reset SHALL force alu_aluop=2'b00, alu_func=4'b0000, alu_a=0, alu_b=0, and req_ready[0]=req_ready[1]=0 on the first cycle after rst is released with req_valid low.
REQ-029 Reset asserted mid-operation (EXEC or RESP) SHALL discard the in-flight op with no response, and SHALL set the round-robin pointer to "last granted = 1".

Configuration
REQ-030 With macro ALU_ARB_ROUND_ROBIN_EN defined, simultaneous requests SHALL be granted to the requester not granted last, and the pointer SHALL update on every acceptance.
REQ-031 Without ALU_ARB_ROUND_ROBIN_EN defined, simultaneous requests SHALL use fixed priority with requester 0 winning, and no pointer state SHALL exist.

Verification
REQ-032 Single op: requester 0 sends aluop=10, func=0000, a=5, b=7 -> one cycle later alu_* show that op -> the next cycle resp_valid=1, resp_id=0, resp_result=12, resp_err=0.
REQ-033 Contention with RR: both requesters are valid continuously, resp_ready=1 -> grants go 0,1,0,1 with resp_valid asserted every 2nd cycle; without the macro, all grants go to 0.
REQ-034 Backpressure: resp_ready=0 for 5 cycles in RESP -> resp_* held stable and req_ready=0 throughout; resp_ready=1 -> the pending request is accepted in the same cycle.
REQ-035 Invalid op: aluop=10, func=1111 -> resp_err=1, with resp_result equal to alu_result as driven.
REQ-036 Reset during RESP with resp_valid=1 -> the next cycle has resp_valid=0 and state IDLE; with both requesters then valid, requester 0 wins the next grant.
